// File: rtl/tsbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tsbus_pkg
// Description : Shared types, default parameters and width helpers for the
//               tri-state bus driver controller.
// Revision    : 1.0 - initial release
// ============================================================================
package tsbus_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } tsbus_state_t;

    // Default configuration
    localparam int c_DEF_N      = 4;
    localparam int c_DEF_WIDTH  = 8;
    localparam int c_DEF_SETTLE = 2;
    localparam int c_DEF_TURN   = 1;

    // Bits needed to hold values 0..max_val, never less than one bit
    function automatic int f_width_min1(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Larger of two integers
    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : tsbus_pkg
`default_nettype wire

// File: rtl/tsbus_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : tsbus_rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of req searching upward from ptr, wrapping at N.
// Revision    : 1.0 - initial release
// ============================================================================
module tsbus_rr_pick
    import tsbus_pkg::*;
#(
    parameter int N     = c_DEF_N,
    parameter int IDX_W = f_width_min1(N - 1)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    // Scan offsets 0..N-1 from ptr; the first requesting candidate wins
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!valid && req[k] && (((int'(ptr) + i) % N) == k)) begin
                    valid     = 1'b1;
                    idx       = IDX_W'(k);
                    onehot[k] = 1'b1;
                end
            end
        end
    end

endmodule : tsbus_rr_pick
`default_nettype wire

// File: rtl/tsbus_driver_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tsbus_driver_ctrl
// Description : Round-robin owner selection for a shared bus built from
//               enable-gated inverting tri-state drivers. Presents inverted
//               data so the bus carries true data, holds one owner for
//               SETTLE+1 cycles and forces TURN all-off cycles between owners.
// Revision    : 1.0 - initial release
// ============================================================================
module tsbus_driver_ctrl
    import tsbus_pkg::*;
#(
    parameter int N      = c_DEF_N,
    parameter int WIDTH  = c_DEF_WIDTH,
    parameter int SETTLE = c_DEF_SETTLE,
    parameter int TURN   = c_DEF_TURN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wdata,
    output logic [N-1:0]         en,
    output logic [WIDTH-1:0]     drv_a,
    output logic [N-1:0]         gnt,
    output logic                 bus_valid,
    output logic                 busy
);

    localparam int c_IDX_W = f_width_min1(N - 1);
    localparam int c_CNT_W = f_width_min1(f_max(SETTLE, TURN));

    localparam logic [c_CNT_W-1:0] c_CNT_SETTLE = c_CNT_W'(SETTLE);
    localparam logic [c_CNT_W-1:0] c_CNT_TURN   = c_CNT_W'(TURN - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(N - 1);

    // The TURN parameter hides the imported state literal, so the
    // turnaround state is always referenced through the package.
    tsbus_state_t        r_state;
    tsbus_state_t        w_next_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_next_cnt;
    logic [c_IDX_W-1:0]  r_ptr;
    logic [c_IDX_W-1:0]  w_next_ptr;
    logic [c_IDX_W-1:0]  r_owner;
    logic [c_IDX_W-1:0]  w_next_owner;

    logic                w_pick_valid;
    logic [c_IDX_W-1:0]  w_pick_idx;
    logic [N-1:0]        w_pick_onehot;
    logic [WIDTH-1:0]    w_sel_data;

    logic [N-1:0]        w_en_d;
    logic [WIDTH-1:0]    w_drv_a_d;
    logic [N-1:0]        w_gnt_d;
    logic                w_bus_valid_d;
    logic                w_busy_d;

    tsbus_rr_pick #(
        .N      (N),
        .IDX_W  (c_IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .valid  (w_pick_valid),
        .idx    (w_pick_idx),
        .onehot (w_pick_onehot)
    );

    // State, phase counter, round-robin pointer and owner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_ptr   <= w_next_ptr;
            r_owner <= w_next_owner;
        end
    end

    // Next-state logic: arbitrate in IDLE, count out DRIVE and TURN phases
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_ptr   = r_ptr;
        w_next_owner = r_owner;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = DRIVE;
                    w_next_cnt   = '0;
                    w_next_owner = w_pick_idx;
                end
            end
            DRIVE: begin
                if (r_cnt == c_CNT_SETTLE) begin
                    w_next_state = tsbus_pkg::TURN;
                    w_next_cnt   = '0;
                    w_next_ptr   = (r_owner == c_IDX_LAST) ? '0 : r_owner + 1'b1;
                end else begin
                    w_next_cnt   = r_cnt + 1'b1;
                end
            end
            tsbus_pkg::TURN: begin
                if (r_cnt == c_CNT_TURN) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Output decode: next-cycle output values derived from the next state
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_pick_idx == c_IDX_W'(k)) begin
                w_sel_data = wdata[k*WIDTH +: WIDTH];
            end
        end

        w_en_d    = '0;
        w_drv_a_d = drv_a;
        if (r_state == IDLE && w_pick_valid) begin
            // Data is captured once on entry and frozen for the whole DRIVE
            w_en_d    = w_pick_onehot;
            w_drv_a_d = ~w_sel_data;
        end else if (w_next_state == DRIVE) begin
            w_en_d    = en;
        end

        w_bus_valid_d = (w_next_state == DRIVE) && (w_next_cnt == c_CNT_SETTLE);
        w_gnt_d       = w_bus_valid_d ? w_en_d : '0;
        w_busy_d      = (w_next_state != IDLE);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            en        <= '0;
            drv_a     <= '0;
            gnt       <= '0;
            bus_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            en        <= w_en_d;
            drv_a     <= w_drv_a_d;
            gnt       <= w_gnt_d;
            bus_valid <= w_bus_valid_d;
            busy      <= w_busy_d;
        end
    end

endmodule : tsbus_driver_ctrl
`default_nettype wire
